// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational ALU between NREQ requesters.
// Optional op counter with stats_clr/op_count ports when ALU_ARB_STATS_EN is defined.
module alu_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int SEL_W = 4,
    parameter int ID_W  = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*WIDTH-1:0]  req_a,
    input  logic [NREQ*WIDTH-1:0]  req_b,
    input  logic [NREQ*SEL_W-1:0]  req_sel,
    input  logic [NREQ-1:0]        req_mode,
    input  logic [NREQ-1:0]        req_cin,
    output logic [WIDTH-1:0]       alu_in_a,
    output logic [WIDTH-1:0]       alu_in_b,
    output logic [SEL_W-1:0]       alu_select,
    output logic                   alu_mode,
    output logic                   alu_carry_in,
    input  logic [WIDTH-1:0]       alu_out,
    input  logic                   alu_carry_out,
    input  logic                   alu_compare,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [WIDTH-1:0]       rsp_out,
    output logic                   rsp_cout,
    output logic                   rsp_cmp
`ifdef ALU_ARB_STATS_EN
    ,
    input  logic                   stats_clr,
    output logic [15:0]            op_count
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t            r_state, w_state_nxt;
    logic [ID_W-1:0]   r_last, r_id_q;
    logic [WIDTH-1:0]  r_alu_a, r_alu_b;
    logic [SEL_W-1:0]  r_alu_sel;
    logic              r_alu_mode, r_alu_cin;
    logic              r_rsp_valid;
    logic [ID_W-1:0]   r_rsp_id;
    logic [WIDTH-1:0]  r_rsp_out;
    logic              r_rsp_cout, r_rsp_cmp;

    logic [ID_W-1:0]   w_idx [NREQ];
    logic [WIDTH-1:0]  w_a   [NREQ];
    logic [WIDTH-1:0]  w_b   [NREQ];
    logic [SEL_W-1:0]  w_sel [NREQ];
    logic              w_found, w_ok, w_accept;
    logic [ID_W-1:0]   w_gnt;

    // w_idx[k] is the k-th candidate in search order, starting just after the last winner
    for (genvar k = 0; k < NREQ; k++) begin : g_req
        assign w_idx[k] = ID_W'((int'(r_last) + k + 1) % NREQ);
        assign w_a[k]   = req_a[k*WIDTH +: WIDTH];
        assign w_b[k]   = req_b[k*WIDTH +: WIDTH];
        assign w_sel[k] = req_sel[k*SEL_W +: SEL_W];
    end

    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && req_valid[w_idx[k]]) begin
                w_found = 1'b1;
                w_gnt   = w_idx[k];
            end
        end
    end

    assign w_ok      = (r_state == S_IDLE) || (r_state == S_RESP && rsp_ready);
    assign w_accept  = w_ok && w_found;
    assign req_ready = w_accept ? ({{(NREQ-1){1'b0}}, 1'b1} << w_gnt) : '0;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = S_EXEC;
            S_EXEC: w_state_nxt = S_RESP;
            S_RESP: if (rsp_ready) w_state_nxt = w_accept ? S_EXEC : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_last     <= ID_W'(NREQ - 1);
            r_id_q     <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_sel  <= '0;
            r_alu_mode <= 1'b0;
            r_alu_cin  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_last     <= w_gnt;
                r_id_q     <= w_gnt;
                r_alu_a    <= w_a[w_gnt];
                r_alu_b    <= w_b[w_gnt];
                r_alu_sel  <= w_sel[w_gnt];
                r_alu_mode <= req_mode[w_gnt];
                r_alu_cin  <= req_cin[w_gnt];
            end
        end
    end

    // Result is captured at the end of the single EXEC cycle; a handshake in RESP drops valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_out   <= '0;
            r_rsp_cout  <= 1'b0;
            r_rsp_cmp   <= 1'b0;
        end else if (r_state == S_EXEC) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id_q;
            r_rsp_out   <= alu_out;
            r_rsp_cout  <= alu_carry_out;
            r_rsp_cmp   <= alu_compare;
        end else if (r_state == S_RESP && rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [15:0] r_op_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_op_count <= '0;
        else if (stats_clr)
            r_op_count <= '0;
        else if (r_rsp_valid && rsp_ready && r_op_count != 16'hFFFF)
            r_op_count <= r_op_count + 16'd1;
    end

    assign op_count = r_op_count;
`endif

    assign alu_in_a     = r_alu_a;
    assign alu_in_b     = r_alu_b;
    assign alu_select   = r_alu_sel;
    assign alu_mode     = r_alu_mode;
    assign alu_carry_in = r_alu_cin;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_id       = r_rsp_id;
    assign rsp_out      = r_rsp_out;
    assign rsp_cout     = r_rsp_cout;
    assign rsp_cmp      = r_rsp_cmp;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed scenarios then randomized traffic,
// checked against a transaction-level model of arbitration and ALU results.
module tb_alu_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int SEL_W = 4;
    localparam int ID_W  = $clog2(NREQ);

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid, req_ready;
    logic [NREQ*WIDTH-1:0] req_a, req_b;
    logic [NREQ*SEL_W-1:0] req_sel;
    logic [NREQ-1:0]       req_mode, req_cin;
    logic [WIDTH-1:0]      alu_in_a, alu_in_b, alu_out;
    logic [SEL_W-1:0]      alu_select;
    logic                  alu_mode, alu_carry_in, alu_carry_out, alu_compare;
    logic                  rsp_valid, rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [WIDTH-1:0]      rsp_out;
    logic                  rsp_cout, rsp_cmp;
`ifdef ALU_ARB_STATS_EN
    logic                  stats_clr;
    logic [15:0]           op_count;
`endif

    always #5 clk = ~clk;

    alu_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .SEL_W(SEL_W), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
        .req_mode(req_mode), .req_cin(req_cin),
        .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_select(alu_select),
        .alu_mode(alu_mode), .alu_carry_in(alu_carry_in),
        .alu_out(alu_out), .alu_carry_out(alu_carry_out), .alu_compare(alu_compare),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_out(rsp_out), .rsp_cout(rsp_cout), .rsp_cmp(rsp_cmp)
`ifdef ALU_ARB_STATS_EN
        ,
        .stats_clr(stats_clr), .op_count(op_count)
`endif
    );

    // Bench ALU: returns {compare, carry_out, out}
    function automatic logic [WIDTH+1:0] alu_f(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                input logic [SEL_W-1:0] s, input logic m, input logic c);
        logic [WIDTH:0] t;
        t = '0;
        if (!m)
            t = s[0] ? ({1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, c})
                     : ({1'b0, a} + {1'b0, b}  + {{WIDTH{1'b0}}, c});
        else
            case (s[1:0])
                2'd0:    t = {1'b0, a & b};
                2'd1:    t = {1'b0, a | b};
                2'd2:    t = {1'b0, a ^ b};
                default: t = {1'b0, ~a};
            endcase
        return {a == b, t};
    endfunction

    always_comb {alu_compare, alu_carry_out, alu_out} = alu_f(alu_in_a, alu_in_b, alu_select, alu_mode, alu_carry_in);

    typedef struct {
        logic [ID_W-1:0]  id;
        logic [WIDTH+1:0] r;
    } exp_t;

    exp_t            q[$];
    int              id_log[$];
    int              n_chk = 0, n_fail = 0;
    int              m_phase, m_last, m_ops;
    logic [NREQ-1:0] acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [SEL_W-1:0] s, input logic m, input logic c);
        req_a[i*WIDTH +: WIDTH]   = a;
        req_b[i*WIDTH +: WIDTH]   = b;
        req_sel[i*SEL_W +: SEL_W] = s;
        req_mode[i]               = m;
        req_cin[i]                = c;
    endtask

    task automatic model_reset();
        q.delete();
        m_phase = 0;
        m_last  = NREQ - 1;
        m_ops   = 0;
        acc     = '0;
    endtask

    // One cycle: inputs already applied after a falling edge; predict, compare, advance.
    task automatic step();
        logic [NREQ-1:0] exp_rdy;
        int  g;
        bit  can;
        exp_t e;
        #1;
        exp_rdy = '0;
        g = -1;
        can = (m_phase == 0) || (m_phase == 2 && rsp_ready);
        if (can)
            for (int k = 1; k <= NREQ; k++)
                if (g < 0 && req_valid[(m_last + k) % NREQ]) g = (m_last + k) % NREQ;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
`ifdef ALU_ARB_STATS_EN
        chk("op_count", 32'(op_count), 32'(m_ops));
        if (stats_clr) m_ops = 0;
        else if (m_phase == 2 && rsp_ready && m_ops < 65535) m_ops++;
`endif
        acc = '0;
        if (m_phase == 1) m_phase = 2;
        else if (g >= 0) begin
            e.id = ID_W'(g);
            e.r  = alu_f(req_a[g*WIDTH +: WIDTH], req_b[g*WIDTH +: WIDTH],
                         req_sel[g*SEL_W +: SEL_W], req_mode[g], req_cin[g]);
            q.push_back(e);
            m_last  = g;
            m_phase = 1;
            acc[g]  = 1'b1;
        end else if (m_phase == 2 && rsp_ready) m_phase = 0;
        @(negedge clk);
    endtask

    // Monitor: compares the presented response against the oldest expected entry
    always @(negedge clk) begin
        #2;
        if (!rst && rsp_valid) begin
            if (q.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_valid), 32'(0));
            end else begin
                chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
                chk("rsp_payload", 32'({rsp_cmp, rsp_cout, rsp_out}), 32'(q[0].r));
                if (rsp_ready) begin
                    id_log.push_back(int'(rsp_id));
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        int rr_exp [6];
        rr_exp = '{0, 1, 2, 3, 0, 1};
        rst = 1'b1;
        req_valid = '0; req_a = '0; req_b = '0; req_sel = '0; req_mode = '0; req_cin = '0;
        rsp_ready = 1'b1;
`ifdef ALU_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("reset_rsp", 32'({rsp_valid, rsp_id, rsp_out, rsp_cout, rsp_cmp}), 32'(0));
        chk("reset_alu", 32'({alu_in_a, alu_in_b, alu_select, alu_mode, alu_carry_in}), 32'(0));
        chk("reset_ready", 32'(req_ready), 32'(0));
        @(negedge clk);
        rst = 1'b0;

        // single request on requester 0
        set_req(0, 8'h0F, 8'h01, 4'd0, 1'b0, 1'b0);
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        step();
        chk("single_rsp", 32'({rsp_valid, rsp_id, rsp_cout, rsp_out}), 32'({1'b1, 2'd0, 1'b0, 8'h10}));
        step();
        step();

        // carry through requester 2
        set_req(2, 8'hFF, 8'h01, 4'd0, 1'b0, 1'b1);
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        step();
        chk("carry_rsp", 32'({rsp_valid, rsp_id, rsp_cout, rsp_out}), 32'({1'b1, 2'd2, 1'b1, 8'h01}));
        step();
        step();

        // backpressure in RESP, then same-cycle completion and accept of req1
        set_req(3, 8'h55, 8'h0F, 4'd1, 1'b1, 1'b0);
        req_valid = 4'b1000;
        step();
        req_valid = '0;
        step();
        rsp_ready = 1'b0;
        set_req(1, 8'h20, 8'h30, 4'd1, 1'b0, 1'b1);
        req_valid = 4'b0010;
        repeat (5) step();
        rsp_ready = 1'b1;
        step();
        req_valid = '0;
        repeat (3) step();

        // reset while in EXEC
        set_req(2, 8'h12, 8'h34, 4'd0, 1'b0, 1'b0);
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        rst = 1'b1;
        #1;
        chk("rst_exec_rsp", 32'(rsp_valid), 32'(0));
        chk("rst_exec_alu", 32'({alu_in_a, alu_in_b, alu_select, alu_mode, alu_carry_in}), 32'(0));
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // round-robin with all requesters continuously valid
        for (int i = 0; i < NREQ; i++) set_req(i, 8'(i * 16 + 3), 8'(i + 1), 4'd0, 1'b0, 1'b0);
        id_log.delete();
        req_valid = '1;
        repeat (13) step();
        req_valid = '0;
        repeat (4) step();
        chk("rr_count", 32'(id_log.size() >= 6), 32'(1));
        for (int i = 0; i < 6 && i < id_log.size(); i++) chk("rr_order", 32'(id_log[i]), 32'(rr_exp[i]));

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!(req_valid[i] && !acc[i] && $urandom_range(9) != 0)) begin
                    req_valid[i] = ($urandom_range(2) == 0);
                    set_req(i, 8'($urandom), 8'($urandom), 4'($urandom_range(3)),
                            1'($urandom_range(1)), 1'($urandom_range(1)));
                end
            end
            rsp_ready = ($urandom_range(3) != 0);
`ifdef ALU_ARB_STATS_EN
            stats_clr = ($urandom_range(19) == 0);
`endif
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
`ifdef ALU_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (4) step();
        chk("queue_drained", 32'(q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
